fft_addr_gen: RTL and testbench

- Address/sequence generator for the 64-point radix-2 DIT FFT sample SRAM; sits directly below the MCU and takes its addr_mode, read_enable, input_ena and output_ena.
- Returns the progress signals the MCU waits on: samples_in_count_out, iteration_strobe, stage_done and output_done.
- Drives the dual-port SRAM addresses and strobes plus the twiddle ROM index for the load, compute and unload phases.

---
 rtl/fft_addr_gen.sv | 268 ++++++++++++++++++++++++++
 tb/tb_fft_addr_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_addr_gen.sv
// ---------------------------------------------------------------------------
// fft_addr_gen
//
// Address and sequence generator for the sample SRAM of a 64-point radix-2
// DIT FFT. It sits below the MCU, follows its addr_mode / enable handshakes,
// and drives the dual-port SRAM strobes and addresses plus the twiddle ROM
// index for the load, compute and unload phases.
//
// Parameters
//   ADDR_W    SRAM address width (N = 2**ADDR_W points, ADDR_W stages).
//   BFLY_LAT  cycles from a butterfly read issue to its write issue (1..7).
//
// Ports
//   clk, n_rst            clock (rising edge), asynchronous active-low reset
//   addr_mode[1:0]        00 idle, 01 load, 10 compute, 11 unload
//   input_ena             one input sample valid this cycle (load)
//   output_ena            output register accepts one word (unload)
//   read_enable           butterfly reads permitted (compute)
//   samples_in_count_out  samples loaded so far, 0..N
//   iteration_strobe      pulse when the N-th sample is written
//   stage_done            pulse with the last write of the final stage
//   output_done           pulse with the N-th unload read
//   rd_en, rd_addr_a/b    SRAM read strobe and addresses
//   wr_en, wr_addr_a/b    SRAM write strobe and addresses
//   twiddle_idx           twiddle ROM index, aligned with rd_en
//   stage_cnt             stage of the most recent butterfly read
//
// Build option
//   FFT_ADDR_BITREV_LOAD_EN defined: load writes bit-reversed addresses and
//   unload reads naturally. Undefined (default): load writes naturally and
//   unload reads bit-reversed addresses.
//
// Every output is a register; the cycle on which addr_mode changes is a dead
// cycle that clears all counters, flushes the write pipeline and fires nothing.
// ---------------------------------------------------------------------------
module fft_addr_gen #(
  parameter int ADDR_W   = 6,
  parameter int BFLY_LAT = 3
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [1:0]        addr_mode,
  input  logic              input_ena,
  input  logic              output_ena,
  input  logic              read_enable,
  output logic [ADDR_W:0]   samples_in_count_out,
  output logic              iteration_strobe,
  output logic              stage_done,
  output logic              output_done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr_a,
  output logic [ADDR_W-1:0] wr_addr_b,
  output logic [ADDR_W-2:0] twiddle_idx,
  output logic [2:0]        stage_cnt
);

  localparam int NPTS = 1 << ADDR_W;

  localparam logic [1:0] MODE_IDLE    = 2'b00;
  localparam logic [1:0] MODE_LOAD    = 2'b01;
  localparam logic [1:0] MODE_COMPUTE = 2'b10;
  localparam logic [1:0] MODE_UNLOAD  = 2'b11;

  localparam logic [ADDR_W:0]   CNT_FULL = NPTS;
  localparam logic [ADDR_W:0]   CNT_LAST = NPTS - 1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-2:0] K_LAST   = (NPTS / 2) - 1;
  localparam logic [ADDR_W-2:0] K_ONE    = 1;
  localparam logic [ADDR_W-1:0] A_ONE    = 1;
  localparam logic [2:0]        S_LAST   = ADDR_W - 1;

  typedef enum logic [1:0] {
    C_RUN,    // issuing butterflies of the current stage
    C_DRAIN,  // last read of a stage issued, waiting for its writes to land
    C_DONE    // last read of the final stage issued, no more reads
  } cstate_t;

  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] v);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) r[i] = v[ADDR_W-1-i];
    return r;
  endfunction

  // registered state
  logic [1:0]        mode_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   ocount_q;
  logic [ADDR_W-2:0] k_q;
  logic [2:0]        s_q;
  cstate_t           cstate_q;
  cstate_t           cstate_d;

  // write-back pipeline: valid, last-write tag and both addresses per slot
  logic [BFLY_LAT-1:0] pv_q;
  logic [BFLY_LAT-1:0] pl_q;
  logic [ADDR_W-1:0]   pa_q [BFLY_LAT];
  logic [ADDR_W-1:0]   pb_q [BFLY_LAT];

  logic              changed;
  logic              is_compute;
  logic              load_acc;
  logic              unload_acc;
  logic              wb_valid;
  logic              pipe_empty;
  logic [ADDR_W-1:0] load_addr;
  logic [ADDR_W-1:0] unload_addr;

  logic              issue;
  logic [2:0]        cur_s;
  logic [ADDR_W-2:0] cur_k;
  logic [ADDR_W-1:0] k_ext;
  logic [ADDR_W-1:0] span;
  logic [ADDR_W-1:0] pos;
  logic [ADDR_W-1:0] grp;
  logic [ADDR_W-1:0] bf_a;
  logic [ADDR_W-1:0] bf_b;
  logic [ADDR_W-1:0] tw_full;

  assign changed    = (addr_mode != mode_q);
  assign is_compute = !changed && (addr_mode == MODE_COMPUTE);
  assign load_acc   = !changed && (addr_mode == MODE_LOAD) && input_ena &&
                      (count_q != CNT_FULL);
  assign unload_acc = !changed && (addr_mode == MODE_UNLOAD) && output_ena &&
                      (ocount_q != CNT_FULL);
  assign pipe_empty = ~|pv_q;
  assign wb_valid   = is_compute && pv_q[BFLY_LAT-1];

`ifdef FFT_ADDR_BITREV_LOAD_EN
  assign load_addr   = bitrev(count_q[ADDR_W-1:0]);
  assign unload_addr = ocount_q[ADDR_W-1:0];
`else
  assign load_addr   = count_q[ADDR_W-1:0];
  assign unload_addr = bitrev(ocount_q[ADDR_W-1:0]);
`endif

  assign samples_in_count_out = count_q;
  assign stage_cnt            = s_q;

  // ---------------- compute FSM: state register ----------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cstate_q <= C_RUN;
    else        cstate_q <= cstate_d;
  end

  // ---------------- compute FSM: output / issue logic ----------------
  // Leaving DRAIN and issuing the first read of the next stage happen on the
  // same edge, so the new stage's first read lands BFLY_LAT+1 cycles after
  // the previous stage's last read.
  always_comb begin
    issue = 1'b0;
    cur_s = s_q;
    cur_k = k_q;
    if (is_compute && read_enable) begin
      case (cstate_q)
        C_RUN: issue = 1'b1;
        C_DRAIN: begin
          if (pipe_empty) begin
            issue = 1'b1;
            cur_s = s_q + 3'd1;
            cur_k = '0;
          end
        end
        default: issue = 1'b0;
      endcase
    end
  end

  // ---------------- compute FSM: next state ----------------
  always_comb begin
    cstate_d = cstate_q;
    if (changed)
      cstate_d = C_RUN;
    else if (issue && (cur_k == K_LAST))
      cstate_d = (cur_s == S_LAST) ? C_DONE : C_DRAIN;
    else if (issue)
      cstate_d = C_RUN;
  end

  // butterfly address / twiddle arithmetic for (cur_s, cur_k)
  always_comb begin
    k_ext   = {1'b0, cur_k};
    span    = A_ONE << cur_s;
    pos     = k_ext & (span - A_ONE);
    grp     = k_ext >> cur_s;
    bf_a    = (grp << (cur_s + 3'd1)) | pos;
    bf_b    = bf_a + span;
    tw_full = pos << (S_LAST - cur_s);
  end

  // ---------------- write-back pipeline ----------------
  // Advances every cycle regardless of read_enable; a mode change drops
  // everything in flight.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pv_q <= '0;
      pl_q <= '0;
      for (int i = 0; i < BFLY_LAT; i++) begin
        pa_q[i] <= '0;
        pb_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= issue;
      pl_q[0] <= issue && (cur_k == K_LAST) && (cur_s == S_LAST);
      pa_q[0] <= bf_a;
      pb_q[0] <= bf_b;
      for (int i = 1; i < BFLY_LAT; i++) begin
        pv_q[i] <= pv_q[i-1] && !changed;
        pl_q[i] <= pl_q[i-1] && !changed;
        pa_q[i] <= pa_q[i-1];
        pb_q[i] <= pb_q[i-1];
      end
    end
  end

  // ---------------- counters and registered outputs ----------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mode_q           <= MODE_IDLE;
      count_q          <= '0;
      ocount_q         <= '0;
      k_q              <= '0;
      s_q              <= '0;
      rd_en            <= 1'b0;
      rd_addr_a        <= '0;
      rd_addr_b        <= '0;
      twiddle_idx      <= '0;
      wr_en            <= 1'b0;
      wr_addr_a        <= '0;
      wr_addr_b        <= '0;
      iteration_strobe <= 1'b0;
      stage_done       <= 1'b0;
      output_done      <= 1'b0;
    end else begin
      mode_q <= addr_mode;

      if (changed) begin
        count_q  <= '0;
        ocount_q <= '0;
        k_q      <= '0;
        s_q      <= '0;
      end else begin
        if (load_acc)   count_q  <= count_q + CNT_ONE;
        if (unload_acc) ocount_q <= ocount_q + CNT_ONE;
        if (issue) begin
          k_q <= cur_k + K_ONE;
          s_q <= cur_s;
        end
      end

      rd_en       <= issue || unload_acc;
      rd_addr_a   <= issue ? bf_a : (unload_acc ? unload_addr : '0);
      rd_addr_b   <= issue ? bf_b : '0;
      twiddle_idx <= issue ? tw_full[ADDR_W-2:0] : '0;

      wr_en     <= load_acc || wb_valid;
      wr_addr_a <= load_acc ? load_addr : (wb_valid ? pa_q[BFLY_LAT-1] : '0);
      wr_addr_b <= wb_valid ? pb_q[BFLY_LAT-1] : '0;

      iteration_strobe <= load_acc && (count_q == CNT_LAST);
      stage_done       <= wb_valid && pl_q[BFLY_LAT-1];
      output_done      <= unload_acc && (ocount_q == CNT_LAST);
    end
  end

endmodule

// File: tb/tb_fft_addr_gen.sv
module tb_fft_addr_gen;

  localparam int AW  = 6;
  localparam int LAT = 3;
  localparam int NB  = 192;  // 6 stages x 32 butterflies

  logic          clk = 1'b0;
  logic          n_rst;
  logic [1:0]    addr_mode;
  logic          input_ena, output_ena, read_enable;
  logic [AW:0]   samples_in_count_out;
  logic          iteration_strobe, stage_done, output_done;
  logic          rd_en, wr_en;
  logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [AW-2:0] twiddle_idx;
  logic [2:0]    stage_cnt;

  always #5 clk = ~clk;

  fft_addr_gen #(.ADDR_W(AW), .BFLY_LAT(LAT)) dut (
    .clk(clk), .n_rst(n_rst), .addr_mode(addr_mode),
    .input_ena(input_ena), .output_ena(output_ena), .read_enable(read_enable),
    .samples_in_count_out(samples_in_count_out),
    .iteration_strobe(iteration_strobe), .stage_done(stage_done),
    .output_done(output_done), .rd_en(rd_en), .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b), .wr_en(wr_en), .wr_addr_a(wr_addr_a),
    .wr_addr_b(wr_addr_b), .twiddle_idx(twiddle_idx), .stage_cnt(stage_cnt)
  );

  int n_pass = 0, n_total = 0, n_fail = 0;
  int cyc = 0;

  // reference model state
  typedef struct { int due; int a; int b; bit last; } wr_t;
  wr_t        wq[$];
  logic [1:0] m_prev;
  int m_count, m_ocount, m_bi, m_last_rd;
  int e_rd_en, e_rd_a, e_rd_b, e_wr_en, e_wr_a, e_wr_b, e_tw;
  int e_iter, e_sdone, e_odone, e_samples, e_stage;
  bit e_lastrd;

  function automatic int bitrev6(input int v);
    int r = 0;
    for (int i = 0; i < 6; i++) r |= ((v >> i) & 1) << (5 - i);
    return r;
  endfunction

  function automatic int load_addr(input int c);
`ifdef FFT_ADDR_BITREV_LOAD_EN
    return bitrev6(c);
`else
    return c;
`endif
  endfunction

  function automatic int unload_addr(input int c);
`ifdef FFT_ADDR_BITREV_LOAD_EN
    return c;
`else
    return bitrev6(c);
`endif
  endfunction

  function automatic logic [63:0] dut_vec();
    return {20'h0, rd_en, rd_addr_a, rd_addr_b, wr_en, wr_addr_a, wr_addr_b,
            twiddle_idx, stage_cnt, samples_in_count_out, iteration_strobe,
            stage_done, output_done};
  endfunction

  function automatic logic [63:0] exp_vec();
    return {20'h0, 1'(e_rd_en), 6'(e_rd_a), 6'(e_rd_b), 1'(e_wr_en), 6'(e_wr_a),
            6'(e_wr_b), 5'(e_tw), 3'(e_stage), 7'(e_samples), 1'(e_iter),
            1'(e_sdone), 1'(e_odone)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = 2'b00; m_count = 0; m_ocount = 0; m_bi = 0; m_last_rd = -100;
    wq.delete();
  endtask

  // Drive one cycle, advance the model by one clock, compare every output.
  task automatic step(input logic [1:0] md, input logic ie, input logic oe, input logic re);
    int s, k, span, pos, grp, a;
    addr_mode = md; input_ena = ie; output_ena = oe; read_enable = re;
    @(posedge clk);
    cyc++;
    e_rd_en = 0; e_rd_a = 0; e_rd_b = 0; e_wr_en = 0; e_wr_a = 0; e_wr_b = 0;
    e_tw = 0; e_iter = 0; e_sdone = 0; e_odone = 0; e_lastrd = 0;
    if (md != m_prev) begin
      m_prev = md; m_count = 0; m_ocount = 0; m_bi = 0; wq.delete();
    end else begin
      case (md)
        2'b01: if (ie && m_count < 64) begin
          e_wr_en = 1; e_wr_a = load_addr(m_count); e_iter = (m_count == 63);
          m_count++;
        end
        2'b10: begin
          if (wq.size() > 0 && wq[0].due == cyc) begin
            e_wr_en = 1; e_wr_a = wq[0].a; e_wr_b = wq[0].b; e_sdone = wq[0].last;
            void'(wq.pop_front());
          end
          if (re && m_bi < NB &&
              (m_bi % 32 != 0 || m_bi == 0 || cyc >= m_last_rd + LAT + 1)) begin
            s = m_bi / 32; k = m_bi % 32;
            span = 1 << s; pos = k % span; grp = k / span;
            a = grp * 2 * span + pos;
            e_rd_en = 1; e_rd_a = a; e_rd_b = a + span; e_tw = pos * (32 / span);
            wq.push_back('{cyc + LAT, a, a + span, (m_bi == NB - 1)});
            e_lastrd = (m_bi == NB - 1);
            m_last_rd = cyc; m_bi++;
          end
        end
        2'b11: if (oe && m_ocount < 64) begin
          e_rd_en = 1; e_rd_a = unload_addr(m_ocount); e_odone = (m_ocount == 63);
          m_ocount++;
        end
        default: ;
      endcase
    end
    e_samples = m_count;
    e_stage   = (m_bi == 0) ? 0 : (m_bi - 1) / 32;
    #1;
    chk("cycle", dut_vec(), exp_vec());
  endtask

  initial begin
    int pulses;
    logic [1:0] md;

    n_rst = 1'b0; addr_mode = 2'b00;
    input_ena = 1'b0; output_ena = 1'b0; read_enable = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", dut_vec(), 64'h0);
    n_rst = 1'b1;
    repeat (3) step(2'b00, 1'b1, 1'b1, 1'b1);

    // load 64 samples with input_ena held high, then two extra requests
    pulses = 0;
    step(2'b01, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 66; i++) begin
      step(2'b01, 1'b1, 1'b0, 1'b0);
      pulses += int'(iteration_strobe);
      if (i == 1) chk("load_second_addr", 64'(wr_addr_a), 64'(load_addr(1)));
    end
    chk("load_extra_no_wr", 64'(wr_en), 64'd0);
    chk("load_count_full", 64'(samples_in_count_out), 64'd64);
    chk("iter_strobe_once", 64'(pulses), 64'd1);

    // compute with read_enable held high
    step(2'b00, 1'b0, 1'b0, 1'b0);
    step(2'b10, 1'b0, 1'b0, 1'b1);
    step(2'b10, 1'b0, 1'b0, 1'b1);
    chk("first_read", {rd_en, rd_addr_a, rd_addr_b, twiddle_idx},
        {1'b1, 6'd0, 6'd1, 5'd0});
    pulses = 0;
    for (int i = 0; i < 240; i++) begin
      step(2'b10, 1'b0, 1'b0, 1'b1);
      pulses += int'(stage_done);
      if (e_lastrd)
        chk("last_read", {rd_en, rd_addr_a, rd_addr_b, twiddle_idx},
            {1'b1, 6'd31, 6'd63, 5'd31});
    end
    chk("stage_done_once", 64'(pulses), 64'd1);
    chk("final_stage", 64'(stage_cnt), 64'd5);

    // compute with read_enable toggling every other cycle
    step(2'b00, 1'b0, 1'b0, 1'b0);
    step(2'b10, 1'b0, 1'b0, 1'b0);
    pulses = 0;
    for (int i = 0; i < 460; i++) begin
      step(2'b10, 1'b0, 1'b0, (i % 2) == 0);
      pulses += int'(stage_done);
    end
    chk("toggle_stage_done_once", 64'(pulses), 64'd1);

    // unload with output_ena high for 70 cycles
    step(2'b00, 1'b0, 1'b0, 1'b0);
    step(2'b11, 1'b0, 1'b1, 1'b0);
    pulses = 0;
    for (int i = 0; i < 70; i++) begin
      step(2'b11, 1'b0, 1'b1, 1'b0);
      pulses += int'(output_done);
      if (i == 1) chk("unload_second_addr", 64'(rd_addr_a), 64'(unload_addr(1)));
    end
    chk("output_done_once", 64'(pulses), 64'd1);
    chk("unload_quiet", 64'(rd_en), 64'd0);

    // abort a load after 20 samples, return to load
    step(2'b00, 1'b0, 1'b0, 1'b0);
    step(2'b01, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(2'b01, 1'b1, 1'b0, 1'b0);
    chk("abort_count_20", 64'(samples_in_count_out), 64'd20);
    step(2'b00, 1'b1, 1'b0, 1'b0);
    step(2'b01, 1'b1, 1'b0, 1'b0);
    chk("reload_count_zero", 64'(samples_in_count_out), 64'd0);
    step(2'b01, 1'b1, 1'b0, 1'b0);
    chk("reload_first_addr", {wr_en, wr_addr_a}, {1'b1, 6'd0});

    // asynchronous reset in the middle of stage 2
    step(2'b00, 1'b0, 1'b0, 1'b0);
    step(2'b10, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 80; i++) step(2'b10, 1'b0, 1'b0, 1'b1);
    chk("pre_reset_stage2", 64'(stage_cnt), 64'd2);
    #2 n_rst = 1'b0;
    #1;
    chk("async_reset", dut_vec(), 64'h0);
    model_reset();
    @(posedge clk);
    #1 n_rst = 1'b1;
    step(2'b10, 1'b0, 1'b0, 1'b1);
    chk("post_reset", {stage_cnt, wr_en}, {3'd0, 1'b0});

    // randomized mode changes and enables
    md = 2'b10;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 149) == 0) md = 2'($urandom_range(0, 3));
      step(md, ($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 4) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
